ps2_host_tx: RTL and testbench

PS/2 host-to-device transmitter. It sends one command byte to the keyboard, for example 0xED (set LEDs), 0xFF (reset) or 0xF4 (enable). It sits beside KeyboardDecoder on the same PS2_CLK/PS2_DATA pair. The block drives the lines open-drain through two output-enable signals, and the top level ties each pin to 0 when its enable is 1 and to 1'bz otherwise. KeyboardDecoder is gated with busy so it ignores the host frame.

---
 rtl/ps2_host_tx.sv | 269 ++++++++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter with open-drain output enables.
// Optional build macro PS2_TX_RETRY_EN: one automatic resend after the first failure.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 12000,
    parameter int unsigned RTS_CYCLES     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_err,
    output logic [1:0] err_code
);

    localparam int unsigned PHASE_MAX = (INHIBIT_CYCLES > RTS_CYCLES) ? INHIBIT_CYCLES : RTS_CYCLES;
    localparam int PW = $clog2(PHASE_MAX + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_INHIBIT   = 3'd1,
        S_RTS       = 3'd2,
        S_SEND      = 3'd3,
        S_ACK       = 3'd4,
        S_WAIT_IDLE = 3'd5
    } state_t;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

    state_t          state_q, state_d;
    logic [PW-1:0]   cnt_q, cnt_d;
    logic [TW-1:0]   tout_q, tout_d;
    logic [3:0]      bit_q, bit_d;
    logic [7:0]      byte_q, byte_d;
    logic            par_q, par_d;
    logic            clk_oe_q, clk_oe_d;
    logic            data_oe_q, data_oe_d;
    logic            ready_q, ready_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic [1:0]      code_q, code_d;
`ifdef PS2_TX_RETRY_EN
    logic            retry_q, retry_d;
`endif

    logic [2:0]      clk_sync_q;   // [0] meta, [1] synced, [2] previous synced
    logic [1:0]      data_sync_q;
    logic            clk_s, data_s, fe_s, timed_out_s;
    logic            fail_s;
    logic [1:0]      fail_code_s;

    assign clk_s       = clk_sync_q[1];
    assign data_s      = data_sync_q[1];
    assign fe_s        = clk_sync_q[2] & ~clk_sync_q[1];
    assign timed_out_s = (tout_q == TW'(TIMEOUT_CYCLES - 1));

    // Synchronise the raw pin levels; reset to the idle-high line level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync_q  <= 3'b111;
            data_sync_q <= 2'b11;
        end else begin
            clk_sync_q  <= {clk_sync_q[1:0], ps2_clk_in};
            data_sync_q <= {data_sync_q[0], ps2_data_in};
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            tout_q    <= '0;
            bit_q     <= 4'd0;
            byte_q    <= 8'h00;
            par_q     <= 1'b0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            code_q    <= 2'b00;
`ifdef PS2_TX_RETRY_EN
            retry_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tout_q    <= tout_d;
            bit_q     <= bit_d;
            byte_q    <= byte_d;
            par_q     <= par_d;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            code_q    <= code_d;
`ifdef PS2_TX_RETRY_EN
            retry_q   <= retry_d;
`endif
        end
    end

    // Next-state, line drive and failure handling.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        tout_d      = tout_q;
        bit_d       = bit_q;
        byte_d      = byte_q;
        par_d       = par_q;
        clk_oe_d    = clk_oe_q;
        data_oe_d   = data_oe_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        code_d      = code_q;
        fail_s      = 1'b0;
        fail_code_s = 2'b00;
`ifdef PS2_TX_RETRY_EN
        retry_d     = retry_q;
`endif

        case (state_q)
            S_IDLE: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                if (tx_valid) begin
                    byte_d   = tx_data;
                    par_d    = odd_parity(tx_data);
                    cnt_d    = '0;
                    clk_oe_d = 1'b1;
                    state_d  = S_INHIBIT;
                end else begin
                    cnt_d = '0;
                end
            end
            S_INHIBIT: begin
                if (cnt_q == PW'(INHIBIT_CYCLES - 1)) begin
                    cnt_d     = '0;
                    data_oe_d = 1'b1;
                    state_d   = S_RTS;
                end else begin
                    cnt_d = cnt_q + PW'(1);
                end
            end
            S_RTS: begin
                if (cnt_q == PW'(RTS_CYCLES - 1)) begin
                    cnt_d    = '0;
                    clk_oe_d = 1'b0;
                    bit_d    = 4'd0;
                    tout_d   = '0;
                    state_d  = S_SEND;
                end else begin
                    cnt_d = cnt_q + PW'(1);
                end
            end
            S_SEND: begin
                tout_d = tout_q + TW'(1);
                // bit_q holds how many falling edges have been seen so far.
                if (timed_out_s) begin
                    fail_s      = 1'b1;
                    fail_code_s = 2'b10;
                end else if (fe_s) begin
                    if (bit_q < 4'd8) begin
                        data_oe_d = ~byte_q[bit_q[2:0]];
                        bit_d     = bit_q + 4'd1;
                    end else if (bit_q == 4'd8) begin
                        data_oe_d = ~par_q;
                        bit_d     = 4'd9;
                    end else begin
                        data_oe_d = 1'b0;
                        state_d   = S_ACK;
                    end
                end else begin
                    bit_d = bit_q;
                end
            end
            S_ACK: begin
                tout_d = tout_q + TW'(1);
                if (timed_out_s) begin
                    fail_s      = 1'b1;
                    fail_code_s = 2'b10;
                end else if (fe_s) begin
                    if (!data_s) begin
                        state_d = S_WAIT_IDLE;
                    end else begin
                        fail_s      = 1'b1;
                        fail_code_s = 2'b01;
                    end
                end else begin
                    state_d = S_ACK;
                end
            end
            S_WAIT_IDLE: begin
                tout_d = tout_q + TW'(1);
                if (timed_out_s) begin
                    fail_s      = 1'b1;
                    fail_code_s = 2'b10;
                end else if (clk_s && data_s) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
`ifdef PS2_TX_RETRY_EN
                    retry_d = 1'b0;
`endif
                end else begin
                    state_d = S_WAIT_IDLE;
                end
            end
            default: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                state_d   = S_IDLE;
            end
        endcase

        if (fail_s) begin
`ifdef PS2_TX_RETRY_EN
            if (!retry_q) begin
                retry_d   = 1'b1;
                cnt_d     = '0;
                clk_oe_d  = 1'b1;
                data_oe_d = 1'b0;
                state_d   = S_INHIBIT;
            end else begin
                retry_d   = 1'b0;
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                err_d     = 1'b1;
                code_d    = fail_code_s;
                state_d   = S_IDLE;
            end
`else
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            err_d     = 1'b1;
            code_d    = fail_code_s;
            state_d   = S_IDLE;
`endif
        end else begin
            code_d = code_d;
        end

        ready_d = (state_d == S_IDLE);
        busy_d  = (state_d != S_IDLE);
    end

    assign tx_ready    = ready_q;
    assign busy        = busy_q;
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;
    assign tx_done     = done_q;
    assign tx_err      = err_q;
    assign err_code    = code_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx: a PS/2 device model clocks frames out of the DUT
// and compares the sampled line bits against a frame model built from the byte value.
module tb_ps2_host_tx;

    localparam int INH  = 100;
    localparam int RTS  = 16;
    localparam int TOUT = 5000;

    logic       clk = 1'b0;
    logic       rst;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready, ps2_clk_oe, ps2_data_oe, busy, tx_done, tx_err;
    logic [1:0] err_code;
    logic       dev_clk, dev_data;
    logic       ps2_clk_in, ps2_data_in;

    assign ps2_clk_in  = ~ps2_clk_oe  & dev_clk;
    assign ps2_data_in = ~ps2_data_oe & dev_data;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .RTS_CYCLES(RTS), .TIMEOUT_CYCLES(TOUT)) dut (
        .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
        .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe), .busy(busy),
        .tx_done(tx_done), .tx_err(tx_err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc = 0;
    int done_cnt = 0, err_cnt = 0, both_cnt = 0, frame_starts = 0;
    int err_cyc = 0;
    logic [1:0] last_code = 2'b00;
    logic [1:0] err_oe = 2'b00;
    logic       err_rdy = 1'b0;
    logic       clk_oe_prev = 1'b0;

    // device-side observations of the last frame
    logic [10:0] seen;
    int          inh_len, rts_len, rel_cyc;
    bit          got_rts;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        clk_oe_prev <= ps2_clk_oe;
        if (ps2_clk_oe && !clk_oe_prev) frame_starts <= frame_starts + 1;
        if (tx_done) done_cnt <= done_cnt + 1;
        if (tx_done && tx_err) both_cnt <= both_cnt + 1;
        if (tx_err) begin
            err_cnt   <= err_cnt + 1;
            err_cyc   <= cyc;
            last_code <= err_code;
            err_oe    <= {ps2_clk_oe, ps2_data_oe};
            err_rdy   <= tx_ready;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Frame as the device should see it: start, data LSB first, odd parity, stop.
    function automatic logic [10:0] model_frame(input int b);
        logic [10:0] f;
        int ones;
        ones = 0;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            f[1 + i] = ((b >> i) % 2) != 0;
            ones += (b >> i) % 2;
        end
        f[9]  = (ones % 2) == 0;
        f[10] = 1'b1;
        return f;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        tx_data  = b;
        tx_valid = 1'b1;
        step();
        tx_valid = 1'b0;
        check("accept_busy", {31'd0, busy}, 32'd1);
        check("accept_ready", {31'd0, tx_ready}, 32'd0);
    endtask

    // Device model: wait for request-to-send, clock out nclk bits, optionally ACK on clock 11.
    task automatic device_frame(input bit ack, input int nclk);
        int n;
        n = 0; got_rts = 0; seen = '0; inh_len = 0; rts_len = 0;
        while (!ps2_clk_oe && n < 1000) begin step(); n++; end
        while (ps2_clk_oe && !ps2_data_oe && inh_len < 20000) begin inh_len++; step(); end
        while (ps2_clk_oe && ps2_data_oe && rts_len < 20000) begin rts_len++; step(); end
        rel_cyc = cyc;
        got_rts = (rts_len > 0) && !ps2_clk_oe;
        seen[0] = ps2_data_in;
        for (int i = 0; i < 10 && i < nclk; i++) begin
            repeat (20) step();
            dev_clk = 1'b0;
            repeat (40) step();
            seen[1 + i] = ps2_data_in;
            dev_clk = 1'b1;
        end
        if (nclk > 10) begin
            repeat (10) step();
            dev_data = ack ? 1'b0 : 1'b1;
            repeat (10) step();
            dev_clk = 1'b0;
            repeat (40) step();
            dev_clk = 1'b1;
            repeat (10) step();
            dev_data = 1'b1;
        end
    endtask

    task automatic wait_result(input int d0, input int e0, input int limit);
        int n;
        n = 0;
        while (done_cnt == d0 && err_cnt == e0 && n < limit) begin step(); n++; end
        check("wait_result_bound", {31'd0, (n < limit)}, 32'd1);
        step();
    endtask

    task automatic good_frame(input logic [7:0] b, input string tag);
        int d0, e0;
        d0 = done_cnt; e0 = err_cnt;
        send_byte(b);
        device_frame(1'b1, 11);
        check({tag, "_rts"}, {31'd0, got_rts}, 32'd1);
        check({tag, "_bits"}, {21'd0, seen}, {21'd0, model_frame(int'(b))});
        wait_result(d0, e0, 2000);
        check({tag, "_done"}, done_cnt - d0, 32'd1);
        check({tag, "_noerr"}, err_cnt - e0, 32'd0);
        check({tag, "_ready"}, {31'd0, tx_ready}, 32'd1);
    endtask

    initial begin
        int d0, e0, f0;
        logic [7:0] rb;
        rst = 1'b1; tx_valid = 1'b0; tx_data = 8'h00; dev_clk = 1'b1; dev_data = 1'b1;
        repeat (3) step();
        check("rst_ready", {31'd0, tx_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
        check("rst_pulses", {30'd0, tx_done, tx_err}, 32'd0);
        check("rst_code", {30'd0, err_code}, 32'd0);
        rst = 1'b0;
        repeat (3) step();

        // 0xED with inhibit/RTS timing
        good_frame(8'hED, "ed");
        check("ed_inhibit_len", inh_len, INH);
        check("ed_rts_len", rts_len, RTS);

        // 0xF4 with a second request while busy that must be ignored
        f0 = frame_starts; d0 = done_cnt; e0 = err_cnt;
        send_byte(8'hF4);
        repeat (5) step();
        tx_data = 8'h00; tx_valid = 1'b1;
        step();
        tx_valid = 1'b0;
        device_frame(1'b1, 11);
        check("f4_bits", {21'd0, seen}, {21'd0, model_frame(32'hF4)});
        check("f4_parity", {31'd0, seen[9]}, 32'd0);
        wait_result(d0, e0, 2000);
        repeat (300) step();
        check("f4_one_frame", frame_starts - f0, 32'd1);
        check("f4_one_done", done_cnt - d0, 32'd1);

        // randomized bytes
        for (int k = 0; k < 3; k++) begin
            rb = 8'($urandom_range(0, 255));
            good_frame(rb, "rand");
        end

`ifdef PS2_TX_RETRY_EN
        // NACK then ACK: two frames, one done, no error
        d0 = done_cnt; e0 = err_cnt; f0 = frame_starts;
        send_byte(8'hED);
        device_frame(1'b0, 11);
        check("retry1_bits", {21'd0, seen}, {21'd0, model_frame(32'hED)});
        device_frame(1'b1, 11);
        check("retry2_bits", {21'd0, seen}, {21'd0, model_frame(32'hED)});
        wait_result(d0, e0, 2000);
        check("retry_done", done_cnt - d0, 32'd1);
        check("retry_noerr", err_cnt - e0, 32'd0);
        check("retry_frames", frame_starts - f0, 32'd2);
        // two NACKs: one error with code 01
        d0 = done_cnt; e0 = err_cnt;
        send_byte(8'hED);
        device_frame(1'b0, 11);
        device_frame(1'b0, 11);
        wait_result(d0, e0, 2000);
        check("retry_nack_err", err_cnt - e0, 32'd1);
        check("retry_nack_code", {30'd0, last_code}, 32'd1);
        check("retry_nack_nodone", done_cnt - d0, 32'd0);
`else
        // NACK on 0xFF
        d0 = done_cnt; e0 = err_cnt;
        send_byte(8'hFF);
        device_frame(1'b0, 11);
        wait_result(d0, e0, 2000);
        check("nack_err", err_cnt - e0, 32'd1);
        check("nack_code", {30'd0, last_code}, 32'd1);
        check("nack_oe", {30'd0, err_oe}, 32'd0);
        check("nack_ready", {31'd0, err_rdy}, 32'd1);
        check("nack_nodone", done_cnt - d0, 32'd0);

        // device stops clocking after 4 bits -> timeout
        d0 = done_cnt; e0 = err_cnt;
        send_byte(8'($urandom_range(0, 255)));
        device_frame(1'b1, 4);
        wait_result(d0, e0, TOUT + 1000);
        check("tout_err", err_cnt - e0, 32'd1);
        check("tout_code", {30'd0, last_code}, 32'd2);
        check("tout_latency", err_cyc - rel_cyc, TOUT);
        check("tout_oe", {30'd0, err_oe}, 32'd0);
        check("tout_nodone", done_cnt - d0, 32'd0);
`endif

        // reset during SEND bit 3
        send_byte(8'h5A);
        device_frame(1'b1, 3);
        rst = 1'b1;
        #2;
        check("midrst_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_code", {30'd0, err_code}, 32'd0);
        step();
        rst = 1'b0;
        d0 = done_cnt; e0 = err_cnt;
        repeat (TOUT + 500) step();
        check("midrst_quiet", (done_cnt - d0) + (err_cnt - e0), 32'd0);
        check("never_both", both_cnt, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
